// File: rtl/dmem_bus_bridge_if.sv
// Purpose: bundles the Mem-stage dcache port and the shared tagged memory bus seen by dmem_bus_bridge.
// Latency: none (signal bundle only).
// Backpressure: bus request beats are held until bus_reqack; responses are consumed only when bus_respack is high.
// Ports: dcache_* (en/wren/addr/wdata in, rdata/done/err out); bus_req* (cyc/data/tag out, ack in);
//        bus_resp* (cyc/data/tag in, ack out). Modport master = bridge side, slave = Mem stage + bus side.
interface dmem_bus_bridge_if;
    logic        dcache_en;
    logic        dcache_wren;
    logic [63:0] dcache_addr;
    logic [63:0] dcache_wdata;
    logic [63:0] dcache_rdata;
    logic        dcache_done;
    logic        dcache_err;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [11:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [11:0] bus_resptag;
    logic        bus_respack;

    modport master (
        input  dcache_en, dcache_wren, dcache_addr, dcache_wdata,
        output dcache_rdata, dcache_done, dcache_err,
        output bus_reqcyc, bus_req, bus_reqtag,
        input  bus_reqack,
        input  bus_respcyc, bus_resp, bus_resptag,
        output bus_respack
    );

    modport slave (
        output dcache_en, dcache_wren, dcache_addr, dcache_wdata,
        input  dcache_rdata, dcache_done, dcache_err,
        input  bus_reqcyc, bus_req, bus_reqtag,
        output bus_reqack,
        output bus_respcyc, bus_resp, bus_resptag,
        input  bus_respack
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Purpose: turns one 64-bit Mem-stage load/store into address(+data) beats on the tagged memory bus.
// Latency: capture to done is 3 cycles minimum (load: addr, resp, done; store: addr, data, done).
// Backpressure: each request beat is held stable until bus_reqack; loads wait for a tag-matched response.
// Ports: clk, reset_n (async active-low), bus_if (dmem_bus_bridge_if.master: dcache_* and bus_* signals).
// Option: define DMEM_BUS_BRIDGE_TIMEOUT_EN to add a response watchdog of TIMEOUT_CYCLES that completes
//         the load with dcache_err=1 and rdata 64'hDEAD_DEAD_DEAD_DEAD.
module dmem_bus_bridge #(
    parameter logic [7:0] REQ_ID         = 8'h01,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    dmem_bus_bridge_if.master  bus_if
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ_ADDR  = 3'd1,
        REQ_DATA  = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [11:0] RESP_TAG = {1'b0, 3'b000, REQ_ID};

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [63:0] addr_q,  addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        wren_q,  wren_d;
    logic [63:0] rdata_q, rdata_d;

    logic        reqcyc;
    logic [63:0] req;
    logic [11:0] reqtag;
    logic        respack;
    logic        done;

    // Low address bits are dropped when the beat is formed.
    logic        unused_addr_lo;
    assign unused_addr_lo = ^addr_q[2:0];

`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = wren_q;
        rdata_d = rdata_q;
        reqcyc  = 1'b0;
        req     = 64'd0;
        reqtag  = 12'd0;
        respack = 1'b0;
        done    = 1'b0;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        // A level-held enable must drop for a cycle before it can start another request.
        if (!bus_if.dcache_en) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus_if.dcache_en && armed_q) begin
                    addr_d  = bus_if.dcache_addr;
                    wdata_d = bus_if.dcache_wdata;
                    wren_d  = bus_if.dcache_wren;
                    armed_d = 1'b0;
                    state_d = REQ_ADDR;
                end
            end
            REQ_ADDR: begin
                reqcyc = 1'b1;
                req    = {addr_q[63:3], 3'b000};
                reqtag = {wren_q, 3'b000, REQ_ID};
                if (bus_if.bus_reqack) begin
                    state_d = wren_q ? REQ_DATA : WAIT_RESP;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ_DATA: begin
                reqcyc = 1'b1;
                req    = wdata_q;
                reqtag = {wren_q, 3'b000, REQ_ID};
                if (bus_if.bus_reqack) begin
                    state_d = DONE;
                end
            end
            WAIT_RESP: begin
                // Responses for other requesters stay on the bus untouched.
                if (bus_if.bus_respcyc && (bus_if.bus_resptag == RESP_TAG)) begin
                    respack = 1'b1;
                    rdata_d = bus_if.bus_resp;
                    state_d = DONE;
                end
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = 64'hDEAD_DEAD_DEAD_DEAD;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wren_q  <= 1'b0;
            rdata_q <= 64'd0;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus_if.dcache_rdata = rdata_q;
    assign bus_if.dcache_done  = done;
    assign bus_if.bus_reqcyc   = reqcyc;
    assign bus_if.bus_req      = req;
    assign bus_if.bus_reqtag   = reqtag;
    assign bus_if.bus_respack  = respack;
`ifdef DMEM_BUS_BRIDGE_TIMEOUT_EN
    // err_q is only ever set on the transition into DONE, so it lines up with the done pulse.
    assign bus_if.dcache_err   = err_q;
`else
    assign bus_if.dcache_err   = 1'b0;
`endif

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the Mem stage on its dcache_* port; converts single 64-bit load/store requests into transactions on the shared tagged memory bus.
- One outstanding request at a time. Reads: address beat, then wait for a tag-matched response. Writes: address beat, then data beat.
- Returns read data and a one-cycle done pulse to Mem.

Parameters:
- REQ_ID, 8'h01, low 8 bits of every issued bus tag.
- TIMEOUT_CYCLES, 1024, response watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  core clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- dcache_en  in  1  request valid, level; held by Mem until done
- dcache_wren  in  1  1=store, 0=load; qualified by dcache_en
- dcache_addr  in  64  byte address; bits [2:0] ignored
- dcache_wdata  in  64  store data
- dcache_rdata  out  64  load data, valid from the done cycle until the next load completes
- dcache_done  out  1  one-cycle completion pulse
- dcache_err  out  1  one-cycle timeout pulse, coincident with done
- bus_reqcyc  out  1  request beat valid
- bus_req  out  64  address beat {addr[63:3],3'b000}, then data beat
- bus_reqtag  out  12  {wren,3'b000,REQ_ID}
- bus_reqack  in  1  beat accepted this cycle
- bus_respcyc  in  1  response valid
- bus_resp  in  64  response data
- bus_resptag  in  12  response tag
- bus_respack  out  1  response consumed

Behaviour:
- Reset, asynchronous: state=IDLE, armed=1. All outputs are 0, including dcache_rdata. Latched addr/wdata/wren are cleared.
- States:
  - IDLE: if dcache_en && armed, latch addr, wdata and wren; clear armed; go to REQ_ADDR.
  - REQ_ADDR: bus_reqcyc=1, bus_req=aligned address. On bus_reqack, go to REQ_DATA if wren, else WAIT_RESP.
  - REQ_DATA: bus_reqcyc=1, bus_req=latched wdata. On bus_reqack, go to DONE. Stores get no bus response.
  - WAIT_RESP: when bus_respcyc && bus_resptag=={1'b0,3'b000,REQ_ID}, assert bus_respack combinationally in the same cycle, register bus_resp into dcache_rdata, and go to DONE. Responses with a non-matching tag are neither acked nor consumed; stay in WAIT_RESP.
  - DONE: dcache_done=1 for exactly one cycle, then IDLE.
- Re-arm rule:
  - armed is set in any cycle where dcache_en==0 and is cleared on capture.
  - A request is therefore accepted only after dcache_en has been low for at least one cycle since the previous capture.
  - This prevents a still-high en from being re-issued after done.
- bus_reqcyc, bus_req and bus_reqtag stay stable until ack. bus_reqtag is driven from the latched wren.
- Minimum latency with immediate ack and response:
  - Load: capture at cycle 0, addr beat at cycle 1, response at cycle 2, done at cycle 3.
  - Store: capture at cycle 0, addr at cycle 1, data at cycle 2, done at cycle 3.
- Changes to dcache_addr, dcache_wdata or dcache_wren after capture are ignored.
- bus_respcyc in any state other than WAIT_RESP is never acked.
- Reset mid-transaction aborts immediately:
  - No done is issued and bus_reqcyc drops.
  - A response arriving later is not acked while in IDLE.
- Simultaneous reqack and a matching respcyc cannot both apply, because each is only examined in its own state.

Optional Feature:
- Macro: DMEM_BUS_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RESP and increments each cycle spent there.
  - On reaching TIMEOUT_CYCLES with no matching response, go to DONE with dcache_rdata=64'hDEAD_DEAD_DEAD_DEAD and dcache_err=1 for the done cycle.
  - A later stale response is ignored under the IDLE rule.
- Undefined: no counter; WAIT_RESP waits indefinitely; dcache_err is tied to 0.

Test Plan:
- Load with immediate ack and a response of 64'h0123_4567_89AB_CDEF, tag 12'h001, at addr 64'h1007 -> bus_req=64'h1000 with tag 12'h001; dcache_rdata=64'h0123_4567_89AB_CDEF with done on cycle 3; respack is high in the response cycle.
- Store of wdata 64'hCAFE at addr 64'h2000, with ack delayed 3 cycles on each beat -> addr beat held 4 cycles with tag 12'h801, then data beat 64'hCAFE held 4 cycles; done pulses once; no respack.
- During a load, a response with tag 12'h002 arrives first, then tag 12'h001 -> the first is not acked and the state is unchanged; the second is acked and its data returned.
- dcache_en held high for 10 cycles across a completed load -> exactly one bus transaction and one done pulse; a new request is captured only after en goes low then high.
- reset_n pulsed low during WAIT_RESP, then the response arrives -> outputs 0 immediately; respack stays 0; no done.
- With DMEM_BUS_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, no response -> done and err pulse together 16 cycles after WAIT_RESP entry; rdata=64'hDEADDEADDEADDEAD.
